// File: rtl/deserializador_pkg.sv
// Shared definitions for the serial-to-parallel receiver.
// Optional even-parity framing is enabled with the PARITY_EN macro.
package deserializador_pkg;

  localparam logic MSB_PRIMERO = 1'b0;
  localparam logic LSB_PRIMERO = 1'b1;

  typedef enum logic {
    VACIO = 1'b0,
    LLENO = 1'b1
  } estado_buf_t;

  // Number of serial bits per frame: data bits, plus one parity bit when enabled.
  function automatic int largo_trama(input int ancho);
`ifdef PARITY_EN
    return ancho + 1;
`else
    return ancho;
`endif
  endfunction

  // Bit counter width; wide enough for 0..ancho so the parity slot also fits.
  function automatic int ancho_cnt(input int ancho);
    return $clog2(ancho + 1);
  endfunction

endpackage

// File: rtl/acumulador_serie.sv
// Serial accumulator: shift register, bit counter, per-frame MODO latch and,
// when PARITY_EN is defined, running parity. `palabra` is the value the shift
// register takes on this edge, so it carries the finished word both on the
// completion cycle and afterwards while the word waits in the register.
module acumulador_serie
  import deserializador_pkg::*;
#(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_in,
  input  logic             toma,
  input  logic             modo,
  output logic [ANCHO-1:0] palabra,
  output logic             paridad_err,
  output logic             completo
);

  localparam int FRAME = largo_trama(ANCHO);
  localparam int CW    = ancho_cnt(ANCHO);
  localparam logic [CW-1:0] ULTIMO = CW'(FRAME - 1);

  logic [ANCHO-1:0] acc, acc_sig;
  logic [CW-1:0]    cnt, cnt_sig;
  logic             modo_q, modo_act, es_dato;

  // The first bit of a frame uses the live MODO; later bits use the latched copy.
  assign modo_act = (cnt == '0) ? modo : modo_q;
  assign completo = toma && (cnt == ULTIMO);

`ifdef PARITY_EN
  assign es_dato = (cnt < CW'(ANCHO));
`else
  assign es_dato = 1'b1;
`endif

  // Next shift-register and counter values for an accepted bit.
  always_comb begin
    acc_sig = acc;
    cnt_sig = cnt;
    if (toma) begin
      if (es_dato) begin
        if (modo_act == MSB_PRIMERO) acc_sig = {acc[ANCHO-2:0], s_in};
        else                         acc_sig = {s_in, acc[ANCHO-1:1]};
      end
      cnt_sig = completo ? '0 : cnt + 1'b1;
    end
  end

  // Accumulator state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      cnt    <= '0;
      modo_q <= MSB_PRIMERO;
    end else begin
      acc <= acc_sig;
      cnt <= cnt_sig;
      if (toma && cnt == '0) modo_q <= modo;
    end
  end

  assign palabra = acc_sig;

`ifdef PARITY_EN
  logic par, err_q;

  // Running XOR of data bits; on the parity bit, keep the verdict for a held word.
  always_ff @(posedge clk) begin
    if (reset) begin
      par   <= 1'b0;
      err_q <= 1'b0;
    end else if (toma) begin
      if (completo) begin
        par   <= 1'b0;
        err_q <= par ^ s_in;
      end else begin
        par <= par ^ s_in;
      end
    end
  end

  assign paridad_err = completo ? (par ^ s_in) : err_q;
`else
  assign paridad_err = 1'b0;
`endif

endmodule

// File: rtl/deserializador_4_bits.sv
// Serial-to-parallel receiver with a one-word output buffer and backpressure.
// Define PARITY_EN to receive an even-parity bit after each word and flag ERR.
module deserializador_4_bits
  import deserializador_pkg::*;
#(
  parameter int ANCHO = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             S_IN,
  input  logic             S_VALID,
  output logic             S_READY,
  input  logic             MODO,
  output logic [ANCHO-1:0] Q,
  output logic             Q_VALID,
  input  logic             Q_READY,
  output logic             ERR
);

  estado_buf_t      estado, estado_sig;
  logic             pendiente, pendiente_sig;
  logic [ANCHO-1:0] q_reg, q_sig;
  logic             err_reg, err_sig;
  logic             toma, drena, completo, paridad_err;
  logic [ANCHO-1:0] palabra;

  assign toma  = S_VALID && !pendiente;
  assign drena = (estado == LLENO) && Q_READY;

  acumulador_serie #(.ANCHO(ANCHO)) u_acumulador (
    .clk         (CLK),
    .reset       (RESET),
    .s_in        (S_IN),
    .toma        (toma),
    .modo        (MODO),
    .palabra     (palabra),
    .paridad_err (paridad_err),
    .completo    (completo)
  );

  // Buffer next state: load a finished or pending word, or empty on drain.
  always_comb begin
    estado_sig    = estado;
    pendiente_sig = pendiente;
    q_sig         = q_reg;
    err_sig       = err_reg;
    if (completo) begin
      if (estado == VACIO || drena) begin
        q_sig      = palabra;
        err_sig    = paridad_err;
        estado_sig = LLENO;
      end else begin
        pendiente_sig = 1'b1;
      end
    end else if (drena) begin
      if (pendiente) begin
        q_sig         = palabra;
        err_sig       = paridad_err;
        estado_sig    = LLENO;
        pendiente_sig = 1'b0;
      end else begin
        estado_sig = VACIO;
      end
    end
  end

  // Buffer and handshake registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      estado    <= VACIO;
      pendiente <= 1'b0;
      q_reg     <= '0;
      err_reg   <= 1'b0;
    end else begin
      estado    <= estado_sig;
      pendiente <= pendiente_sig;
      q_reg     <= q_sig;
      err_reg   <= err_sig;
    end
  end

  assign S_READY = !pendiente;
  assign Q_VALID = (estado == LLENO);
  assign Q       = q_reg;
  assign ERR     = err_reg;

endmodule

// File: tb/tb_deserializador_4_bits.sv
// Directed bench for deserializador_4_bits (ANCHO=4); follows PARITY_EN.
module tb_deserializador_4_bits;

`ifdef PARITY_EN
  localparam int FRAME = 5;
`else
  localparam int FRAME = 4;
`endif

  logic       CLK = 1'b0;
  logic       RESET, S_IN, S_VALID, MODO, Q_READY;
  logic       S_READY, Q_VALID, ERR;
  logic [3:0] Q;

  int checks = 0;
  int errors = 0;
  int ciclos = 0;
  int n_valid = 0;

  deserializador_4_bits #(.ANCHO(4)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .S_IN    (S_IN),
    .S_VALID (S_VALID),
    .S_READY (S_READY),
    .MODO    (MODO),
    .Q       (Q),
    .Q_VALID (Q_VALID),
    .Q_READY (Q_READY),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       modo;
    logic [3:0] bits;     // bits[3] is sent first
    logic       alterna;  // flip MODO after the first bit
    logic [3:0] q_esp;
  } vec_t;

  vec_t tabla[7];

  task automatic tick();
    @(posedge CLK);
    #1;
    ciclos++;
    if (Q_VALID) n_valid++;
  endtask

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] esp);
    checks++;
    if (act !== esp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nombre, act, esp);
    end
  endtask

  task automatic send_bit(input logic b);
    int n = 0;
    S_VALID = 1'b1;
    S_IN    = b;
    while (!S_READY && n < 40) begin
      tick();
      n++;
    end
    if (!S_READY) begin
      checks++;
      errors++;
      $display("FAIL s_ready_timeout actual=0 required=1");
    end
    tick();
  endtask

  task automatic send_frame(input logic [3:0] b, input logic modo,
                            input logic alterna, input logic par_flip);
    for (int i = 0; i < 4; i++) begin
      MODO = (alterna && i > 0) ? ~modo : modo;
      send_bit(b[3-i]);
    end
`ifdef PARITY_EN
    send_bit((^b) ^ par_flip);
`endif
    S_VALID = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_q"},       Q,       4'h0);
    chk({tag, "_qvalid"},  Q_VALID, 1'b0);
    chk({tag, "_err"},     ERR,     1'b0);
    chk({tag, "_sready"},  S_READY, 1'b1);
  endtask

  initial begin
    int t0;
    logic [4:0] gseq;

    tabla[0] = '{1'b0, 4'b1011, 1'b0, 4'hB};
    tabla[1] = '{1'b1, 4'b1011, 1'b0, 4'hD};
    tabla[2] = '{1'b1, 4'b1011, 1'b1, 4'hD};
    tabla[3] = '{1'b0, 4'b1011, 1'b1, 4'hB};
    tabla[4] = '{1'b0, 4'b0001, 1'b0, 4'h1};
    tabla[5] = '{1'b1, 4'b0001, 1'b0, 4'h8};
    tabla[6] = '{1'b1, 4'b1110, 1'b0, 4'h7};

    RESET = 1'b1; S_VALID = 1'b0; S_IN = 1'b0; MODO = 1'b0; Q_READY = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    chk_reset("reset");

    // Table: one frame each, consumer always ready
    for (int k = 0; k < 7; k++) begin
      send_frame(tabla[k].bits, tabla[k].modo, tabla[k].alterna, 1'b0);
      chk($sformatf("vec%0d_q", k),      Q,       tabla[k].q_esp);
      chk($sformatf("vec%0d_qvalid", k), Q_VALID, 1'b1);
      chk($sformatf("vec%0d_err", k),    ERR,     1'b0);
      tick();
      chk($sformatf("vec%0d_pulse", k),  Q_VALID, 1'b0);
    end

    // Back-to-back frames: one word every FRAME cycles
    send_frame(4'h9, 1'b0, 1'b0, 1'b0);
    chk("b2b_q1", Q, 4'h9);
    t0 = ciclos;
    send_frame(4'h6, 1'b0, 1'b0, 1'b0);
    chk("b2b_cycles", ciclos - t0, FRAME);
    chk("b2b_q2", Q, 4'h6);
    tick();

    // Backpressure: second word waits in the accumulator
    Q_READY = 1'b0;
    send_frame(4'hA, 1'b0, 1'b0, 1'b0);
    chk("bp_q_first", Q, 4'hA);
    chk("bp_sready_first", S_READY, 1'b1);
    send_frame(4'h5, 1'b0, 1'b0, 1'b0);
    chk("bp_sready_pend", S_READY, 1'b0);
    chk("bp_q_hold", Q, 4'hA);
    chk("bp_qvalid_hold", Q_VALID, 1'b1);
    repeat (3) tick();
    chk("bp_q_stable", Q, 4'hA);
    chk("bp_sready_stable", S_READY, 1'b0);
    Q_READY = 1'b1;
    tick();
    chk("bp_q_second", Q, 4'h5);
    chk("bp_qvalid_second", Q_VALID, 1'b1);
    chk("bp_sready_back", S_READY, 1'b1);
    tick();
    chk("bp_drained", Q_VALID, 1'b0);

    // Drain and completion on the same edge: no bubble
    Q_READY = 1'b0;
    send_frame(4'h3, 1'b0, 1'b0, 1'b0);
    MODO = 1'b0;
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
`ifdef PARITY_EN
    send_bit(1'b0);
`endif
    Q_READY = 1'b1;
    send_bit(1'b0);
    S_VALID = 1'b0;
    chk("swap_q", Q, 4'hC);
    chk("swap_qvalid", Q_VALID, 1'b1);
    chk("swap_sready", S_READY, 1'b1);
    tick();
    chk("swap_drained", Q_VALID, 1'b0);

    // Reset mid-frame with a buffered word and a bit offered during reset
    Q_READY = 1'b0;
    send_frame(4'h7, 1'b0, 1'b0, 1'b0);
    MODO = 1'b0;
    send_bit(1'b1); send_bit(1'b1);
    RESET = 1'b1; S_VALID = 1'b1; S_IN = 1'b1;
    tick();
    RESET = 1'b0; S_VALID = 1'b0;
    chk_reset("midrst");
    Q_READY = 1'b1;
    send_frame(4'b0001, 1'b0, 1'b0, 1'b0);
    chk("midrst_q", Q, 4'h1);
    chk("midrst_qvalid", Q_VALID, 1'b1);
    tick();

    // Gaps of three idle cycles between bits
    n_valid = 0;
    MODO = 1'b0;
    gseq = {4'b0110, 1'b0};
    for (int i = 0; i < FRAME; i++) begin
      send_bit(gseq[4-i]);
      S_VALID = 1'b0;
      if (i == FRAME - 1) begin
        chk("gap_q", Q, 4'h6);
        chk("gap_qvalid", Q_VALID, 1'b1);
      end
      repeat (3) tick();
    end
    chk("gap_pulses", n_valid, 1);

`ifdef PARITY_EN
    send_frame(4'hC, 1'b0, 1'b0, 1'b0);
    chk("par_ok_q", Q, 4'hC);
    chk("par_ok_err", ERR, 1'b0);
    tick();
    send_frame(4'hC, 1'b0, 1'b0, 1'b1);
    chk("par_bad_q", Q, 4'hC);
    chk("par_bad_err", ERR, 1'b1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
